// File: rtl/sys_control_multi.sv
// System control for the color-detect pipeline: camera-config sequencing with
// timeout/retry, debounced filter switches and SOF-aligned filter commits.
module sys_control_multi #(
  parameter int N_FILT      = 4,
  parameter int DB_CYCLES   = 16,
  parameter int CFG_TIMEOUT = 1000000
) (
  input  logic              i_sysclk,
  input  logic              i_rstn,
  input  logic              i_sof,
  input  logic              i_cfg_done,
  input  logic [N_FILT-1:0] i_sw_filt,
  input  logic              i_btn_reconfig,
  output logic              o_cfg_start,
  output logic              o_pipe_flush,
  output logic [N_FILT-1:0] o_filt_enable,
  output logic [7:0]        o_status_leds
);

  localparam int N_IN = N_FILT + 1;
  localparam int DBW  = $clog2(DB_CYCLES + 1);
  localparam int TW   = $clog2(CFG_TIMEOUT + 1);

  typedef enum logic [1:0] {CFG_START = 2'd0, CFG_WAIT = 2'd1, CFG_DONE = 2'd2} cfg_state_t;
  typedef enum logic [1:0] {FL_INIT = 2'd0, FL_IDLE = 2'd1, FL_ACTIVE = 2'd2} fl_state_t;

  logic [N_IN-1:0]   raw_in;
  logic [N_IN-1:0]   db_vec;
  logic [N_FILT-1:0] db_mask;
  logic              db_btn;
  logic              btn_prev_reg;
  logic              btn_rise;

  assign raw_in = {i_btn_reconfig, i_sw_filt};

  // Button sits in the top slot so switches and button share one conditioner.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_cond
      logic           sync1_reg;
      logic           sync2_reg;
      logic           db_reg;
      logic [DBW-1:0] cnt_reg;

      always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          db_reg    <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DBW'(DB_CYCLES - 1)) begin
            db_reg  <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign db_vec[gi] = db_reg;
    end
  endgenerate

  assign db_mask  = db_vec[N_FILT-1:0];
  assign db_btn   = db_vec[N_FILT];
  assign btn_rise = db_btn & ~btn_prev_reg;

  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) btn_prev_reg <= 1'b0;
    else         btn_prev_reg <= db_btn;
  end

  cfg_state_t     cfg_state_reg;
  logic           cfg_start_reg;
  logic [TW-1:0]  tmo_reg;
  logic [2:0]     retry_reg;

  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      cfg_state_reg <= CFG_START;
      cfg_start_reg <= 1'b0;
      tmo_reg       <= '0;
      retry_reg     <= 3'd0;
    end else begin
      cfg_start_reg <= 1'b0;
      case (cfg_state_reg)
        CFG_START: begin
          cfg_start_reg <= 1'b1;
          tmo_reg       <= '0;
          cfg_state_reg <= CFG_WAIT;
        end
        CFG_WAIT: begin
          if (i_cfg_done) begin
            cfg_state_reg <= CFG_DONE;
          end else if (tmo_reg == TW'(CFG_TIMEOUT - 1)) begin
            cfg_state_reg <= CFG_START;
            if (retry_reg != 3'd7) retry_reg <= retry_reg + 3'd1;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        CFG_DONE: begin
          // A dropped i_cfg_done here is deliberately ignored; only the button re-runs config.
          if (btn_rise) begin
            cfg_state_reg <= CFG_START;
            retry_reg     <= 3'd0;
          end
        end
        default: cfg_state_reg <= CFG_START;
      endcase
    end
  end

  fl_state_t         fl_state_reg;
  logic              flush_reg;
  logic [N_FILT-1:0] filt_reg;
  logic [7:0]        leds_reg;
  logic [2:0]        filt_pad;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pad
      if (gi < N_FILT) begin : g_bit
        assign filt_pad[gi] = filt_reg[gi];
      end else begin : g_zero
        assign filt_pad[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      fl_state_reg <= FL_INIT;
      flush_reg    <= 1'b1;
      filt_reg     <= '0;
      leds_reg     <= 8'd0;
    end else begin
      // Flush tracks the state one cycle late so it spans the commit SOF.
      flush_reg <= (fl_state_reg != FL_IDLE);
      leds_reg  <= {filt_pad, retry_reg, flush_reg, (cfg_state_reg == CFG_DONE)};
      case (fl_state_reg)
        FL_INIT: begin
          if ((cfg_state_reg == CFG_DONE) && i_sof) begin
            filt_reg     <= db_mask;
            fl_state_reg <= FL_IDLE;
          end
        end
        FL_IDLE: begin
          if (btn_rise)                 fl_state_reg <= FL_INIT;
          else if (db_mask != filt_reg) fl_state_reg <= FL_ACTIVE;
        end
        FL_ACTIVE: begin
          if (btn_rise) begin
            fl_state_reg <= FL_INIT;
          end else if (i_sof) begin
            filt_reg     <= db_mask;
            fl_state_reg <= FL_IDLE;
          end
        end
        default: fl_state_reg <= FL_INIT;
      endcase
    end
  end

  assign o_cfg_start   = cfg_start_reg;
  assign o_pipe_flush  = flush_reg;
  assign o_filt_enable = filt_reg;
  assign o_status_leds = leds_reg;

endmodule

// File: tb/tb_sys_control_multi.sv
// Directed bench for sys_control_multi: bring-up, debounce, SOF commit,
// config timeout/retry, reconfigure button and mid-operation reset.
module tb_sys_control_multi;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sof;
  logic       cfg_done;
  logic [3:0] sw;
  logic       btn;
  logic       cfg_start;
  logic       flush;
  logic [3:0] filt;
  logic [7:0] leds;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sys_control_multi #(
    .N_FILT(4),
    .DB_CYCLES(16),
    .CFG_TIMEOUT(100)
  ) dut (
    .i_sysclk(clk),
    .i_rstn(rstn),
    .i_sof(sof),
    .i_cfg_done(cfg_done),
    .i_sw_filt(sw),
    .i_btn_reconfig(btn),
    .o_cfg_start(cfg_start),
    .o_pipe_flush(flush),
    .o_filt_enable(filt),
    .o_status_leds(leds)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; sof = 1'b0; cfg_done = 1'b0; sw = 4'b0000; btn = 1'b0;
    step(3);
    n_checks++; if (cfg_start !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_start: got %b want 0", cfg_start); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush: got %b want 1", flush); end
    n_checks++; if (filt !== 4'b0000) begin n_fail++; $display("FAIL reset_filt: got %b want 0000", filt); end
    n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL reset_leds: got %h want 00", leds); end
    $display("test_reset done");
  endtask

  task automatic test_bringup();
    int extra_pulses = 0;
    int flush_low = 0;
    rstn = 1'b1; sw = 4'b0101;
    step(1);
    n_checks++; if (cfg_start !== 1'b1) begin n_fail++; $display("FAIL bringup_pulse_hi: got %b want 1", cfg_start); end
    step(1);
    n_checks++; if (cfg_start !== 1'b0) begin n_fail++; $display("FAIL bringup_pulse_lo: got %b want 0", cfg_start); end
    for (int k = 3; k <= 199; k++) begin
      step(1);
      if (cfg_start !== 1'b0) extra_pulses++;
      if (flush !== 1'b1) flush_low++;
      if (k == 50) cfg_done = 1'b1;
    end
    n_checks++; if (extra_pulses != 0) begin n_fail++; $display("FAIL bringup_extra_pulses: got %0d want 0", extra_pulses); end
    n_checks++; if (flush_low != 0) begin n_fail++; $display("FAIL bringup_flush_held: low cycles %0d want 0", flush_low); end
    sof = 1'b1; step(1); sof = 1'b0;
    n_checks++; if (filt !== 4'b0101) begin n_fail++; $display("FAIL bringup_commit: got %b want 0101", filt); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL bringup_flush_sof: got %b want 1", flush); end
    step(1);
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL bringup_flush_fall: got %b want 0", flush); end
    step(1);
    n_checks++; if (leds !== 8'hA1) begin n_fail++; $display("FAIL bringup_leds: got %h want a1", leds); end
    $display("test_bringup done");
  endtask

  task automatic test_glitch_commit();
    int bad = 0;
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < 10; c++) begin
        sw = (c < 5) ? 4'b0001 : 4'b0101;
        step(1);
        if (flush !== 1'b0) bad++;
      end
    end
    for (int c = 0; c < 25; c++) begin
      step(1);
      if (flush !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL glitch_no_flush: flush high %0d cycles want 0", bad); end
    sof = 1'b1; step(1); sof = 1'b0; step(2);
    n_checks++; if (filt !== 4'b0101) begin n_fail++; $display("FAIL idle_sof_noeffect: got %b want 0101", filt); end
    bad = 0;
    sw = 4'b0001;
    for (int k = 1; k <= 19; k++) begin
      step(1);
      if (flush !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stable_flush_early: high %0d cycles want 0", bad); end
    step(1);
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL stable_flush_rise: got %b want 1", flush); end
    step(10);
    n_checks++; if (filt !== 4'b0101) begin n_fail++; $display("FAIL stable_hold_pre_sof: got %b want 0101", filt); end
    sof = 1'b1; step(1); sof = 1'b0;
    n_checks++; if (filt !== 4'b0001) begin n_fail++; $display("FAIL stable_commit: got %b want 0001", filt); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL stable_flush_at_sof: got %b want 1", flush); end
    step(1);
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL stable_flush_fall: got %b want 0", flush); end
    $display("test_glitch_commit done");
  endtask

  task automatic test_multi_change();
    int bad = 0;
    sw = 4'b0011;
    step(25);
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL multi_flush: got %b want 1", flush); end
    n_checks++; if (filt !== 4'b0001) begin n_fail++; $display("FAIL multi_hold1: got %b want 0001", filt); end
    sw = 4'b0111;
    for (int c = 0; c < 25; c++) begin
      step(1);
      if (filt !== 4'b0001) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL multi_no_intermediate: changed %0d cycles want 0", bad); end
    sof = 1'b1; step(1); sof = 1'b0;
    n_checks++; if (filt !== 4'b0111) begin n_fail++; $display("FAIL multi_commit: got %b want 0111", filt); end
    step(4);
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL multi_flush_fall: got %b want 0", flush); end
    $display("test_multi_change done");
  endtask

  task automatic test_timeout();
    int bad_pulse = 0;
    int bad_retry = 0;
    int first_bad = -1;
    logic       exp_pulse;
    logic [2:0] exp_retry;
    rstn = 1'b0; cfg_done = 1'b0; sof = 1'b0;
    step(2);
    rstn = 1'b1;
    for (int k = 1; k <= 909; k++) begin
      step(1);
      exp_pulse = ((k - 1) % 101 == 0);
      exp_retry = ((k - 1) / 101 >= 7) ? 3'd7 : 3'((k - 1) / 101);
      if (cfg_start !== exp_pulse) begin bad_pulse++; if (first_bad < 0) first_bad = k; end
      if (leds[4:2] !== exp_retry) begin bad_retry++; if (first_bad < 0) first_bad = k; end
    end
    n_checks++; if (bad_pulse != 0) begin n_fail++; $display("FAIL timeout_pulses: %0d bad cycles (first %0d) want 0", bad_pulse, first_bad); end
    n_checks++; if (bad_retry != 0) begin n_fail++; $display("FAIL timeout_retry: %0d bad cycles (first %0d) want 0", bad_retry, first_bad); end
    cfg_done = 1'b1;
    step(5);
    n_checks++; if (leds[0] !== 1'b1) begin n_fail++; $display("FAIL timeout_done_led: got %b want 1", leds[0]); end
    n_checks++; if (leds[4:2] !== 3'd7) begin n_fail++; $display("FAIL timeout_retry_kept: got %0d want 7", leds[4:2]); end
    sof = 1'b1; step(1); sof = 1'b0; step(1);
    n_checks++; if (filt !== 4'b0111) begin n_fail++; $display("FAIL timeout_commit: got %b want 0111", filt); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL timeout_flush_fall: got %b want 0", flush); end
    $display("test_timeout done");
  endtask

  task automatic test_reconfig();
    int pulses = 0;
    cfg_done = 1'b0; btn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (cfg_start === 1'b1) pulses++;
    end
    btn = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step(1);
      if (cfg_start === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL reconfig_pulses: got %0d want 1", pulses); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL reconfig_flush: got %b want 1", flush); end
    n_checks++; if (leds[4:2] !== 3'd0) begin n_fail++; $display("FAIL reconfig_retry_clr: got %0d want 0", leds[4:2]); end
    sof = 1'b1; step(1); sof = 1'b0; step(3);
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL reconfig_sof_early: got %b want 1", flush); end
    cfg_done = 1'b1; step(3);
    sof = 1'b1; step(1); sof = 1'b0; step(1);
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reconfig_release: got %b want 0", flush); end
    $display("test_reconfig done");
  endtask

  task automatic test_reset_midop();
    sw = 4'b0001;
    step(25);
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL midop_pending_flush: got %b want 1", flush); end
    n_checks++; if (filt !== 4'b0111) begin n_fail++; $display("FAIL midop_pending_filt: got %b want 0111", filt); end
    rstn = 1'b0;
    step(1);
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL midop_flush: got %b want 1", flush); end
    n_checks++; if (filt !== 4'b0000) begin n_fail++; $display("FAIL midop_filt: got %b want 0000", filt); end
    n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL midop_leds: got %h want 00", leds); end
    n_checks++; if (cfg_start !== 1'b0) begin n_fail++; $display("FAIL midop_cfg_start: got %b want 0", cfg_start); end
    $display("test_reset_midop done");
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch_commit();
    test_multi_change();
    test_timeout();
    test_reconfig();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
